// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator controller. Builds two BCD operands and an operator from key
// pulses, runs an external ALU through a start/done handshake and drives the BCD display.
module calc_sequencer #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          num_val,
    input  logic [1:0]          op_val,
    input  logic                is_num,
    input  logic                is_op,
    input  logic                is_eq,
    output logic                alu_start,
    output logic [4*DIGITS-1:0] alu_a,
    output logic [4*DIGITS-1:0] alu_b,
    output logic [1:0]          alu_op,
    input  logic                alu_done,
    input  logic [4*DIGITS-1:0] alu_result,
    input  logic                alu_err,
    output logic                busy,
    output logic                err_flag,
    output logic [4*DIGITS-1:0] data_out_bcd
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_WAIT_ALU,
        S_SHOW_RES,
        S_ERROR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_a, w_a_nxt;
    logic [W-1:0]  r_b, w_b_nxt;
    logic [1:0]    r_op, w_op_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;

    logic          r_start, w_start_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_err, w_err_nxt;
    logic [W-1:0]  r_disp, w_disp_nxt;

    logic          w_key_eq;
    logic          w_key_op;
    logic          w_key_num;
    logic          w_digit_ok;
    logic          w_room;
    logic [W-1:0]  w_digit_ext;
    logic [W-1:0]  w_a_shift;
    logic [W-1:0]  w_b_shift;

    // Only the highest-priority key of a cycle is considered; lower ones are dropped.
    assign w_key_eq    = is_eq;
    assign w_key_op    = is_op & ~is_eq;
    assign w_key_num   = is_num & ~is_op & ~is_eq;
    assign w_digit_ok  = w_key_num && (num_val <= 4'd9);
    assign w_room      = (r_cnt < CW'(DIGITS));
    assign w_digit_ext = W'(num_val);
    assign w_a_shift   = W'({r_a, num_val});
    assign w_b_shift   = W'({r_b, num_val});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ENTER_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        case (r_state)
            S_ENTER_A: begin
                if (w_key_op) begin
                    w_op_nxt    = op_val;
                    w_b_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ENTER_B;
                end else if (w_digit_ok && w_room) begin
                    w_a_nxt   = w_a_shift;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_ENTER_B: begin
                if (w_key_eq) begin
                    if (r_cnt != '0) begin
                        w_timer_nxt = '0;
                        w_state_nxt = S_WAIT_ALU;
                    end
                end else if (w_key_op) begin
                    if (r_cnt == '0) begin
                        w_op_nxt = op_val;
                    end
                end else if (w_digit_ok && w_room) begin
                    w_b_nxt   = w_b_shift;
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_ALU: begin
                if (alu_done) begin
                    if (alu_err) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_a_nxt     = alu_result;
                        w_state_nxt = S_SHOW_RES;
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_SHOW_RES: begin
                if (w_key_op) begin
                    w_op_nxt    = op_val;
                    w_b_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ENTER_B;
                end else if (w_digit_ok) begin
                    w_a_nxt     = w_digit_ext;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_ENTER_A;
                end
            end
            S_ERROR: begin
                if (w_digit_ok) begin
                    w_a_nxt     = w_digit_ext;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_ENTER_A;
                end
            end
            default: begin
                w_state_nxt = S_ENTER_A;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so every key shows up one cycle after its pulse.
    always_comb begin
        w_start_nxt = (r_state == S_ENTER_B) && (w_state_nxt == S_WAIT_ALU);
        w_busy_nxt  = (w_state_nxt == S_WAIT_ALU);
        w_err_nxt   = (w_state_nxt == S_ERROR);
        w_disp_nxt  = r_disp;
        case (w_state_nxt)
            S_ENTER_A:  w_disp_nxt = w_a_nxt;
            S_ENTER_B:  w_disp_nxt = (w_cnt_nxt != '0) ? w_b_nxt : w_a_nxt;
            S_WAIT_ALU: w_disp_nxt = r_disp;
            S_SHOW_RES: w_disp_nxt = w_a_nxt;
            S_ERROR:    w_disp_nxt = {DIGITS{4'hE}};
            default:    w_disp_nxt = r_disp;
        endcase
    end

    assign alu_start    = r_start;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_op       = r_op;
    assign busy         = r_busy;
    assign err_flag     = r_err;
    assign data_out_bcd = r_disp;

endmodule
